// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t;

    localparam logic [1:0]  GRANT_NONE    = 2'b00;
    localparam logic [1:0]  GRANT_M0      = 2'b01;
    localparam logic [1:0]  GRANT_M1      = 2'b10;

    // Read data handed back to a master whose access was abandoned by timeout
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_arbiter_if.sv
// PicoRV32-native memory handshake: request from the master, done pulse and read data back.
interface mem_arbiter_if;

    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, instr, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, instr, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/mem_arbiter.sv
// Shares one bram_controller port between the CPU (m0) and a loader/debug master (m1),
// one whole transaction at a time, with a timeout so a hung slave cannot lock the bus.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic [1:0]    grant,
    output logic          timeout_err
);

    localparam int               CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_t       state_q, state_d;
    logic             prio_q, prio_d;     // 1: master 1 wins the next tie
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             granted, timeout_hit, done, m0_wins;

    always_comb begin
        granted     = (state_q != IDLE);
        timeout_hit = TIMEOUT_EN && granted && !s.ready && (cnt_q == CNT_LAST);
        done        = granted && (s.ready || timeout_hit);
        m0_wins     = m0.valid && (!m1.valid || (FIXED_PRIORITY != 0) || !prio_q);
    end

    always_comb begin
        s.valid = 1'b0;
        s.instr = 1'b0;
        s.addr  = '0;
        s.wdata = '0;
        s.wstrb = '0;
        grant   = GRANT_NONE;
        case (state_q)
            GRANT0: begin
                s.valid = 1'b1;
                s.instr = m0.instr;
                s.addr  = m0.addr;
                s.wdata = m0.wdata;
                s.wstrb = m0.wstrb;
                grant   = GRANT_M0;
            end
            GRANT1: begin
                s.valid = 1'b1;
                s.instr = m1.instr;
                s.addr  = m1.addr;
                s.wdata = m1.wdata;
                s.wstrb = m1.wstrb;
                grant   = GRANT_M1;
            end
            default: ;
        endcase
        // The return path is pure passthrough so the arbiter adds no completion latency
        m0.ready    = (state_q == GRANT0) && done;
        m1.ready    = (state_q == GRANT1) && done;
        m0.rdata    = timeout_hit ? TIMEOUT_RDATA : s.rdata;
        m1.rdata    = timeout_hit ? TIMEOUT_RDATA : s.rdata;
        timeout_err = timeout_err_q;
    end

    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q | timeout_hit;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_wins) begin
                    state_d = GRANT0;
                end else if (m1.valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (done) begin
                    state_d = IDLE;
                    prio_d  = (state_q == GRANT0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance (timeout 4) and a fixed-priority instance
// (timeout 1) run side by side against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_arbiter_if a_m0();
    mem_arbiter_if a_m1();
    mem_arbiter_if a_s();
    mem_arbiter_if b_m0();
    mem_arbiter_if b_m1();
    mem_arbiter_if b_s();
    logic [1:0] a_grant, b_grant;
    logic       a_terr, b_terr;

    mem_arbiter #(.TIMEOUT_CYCLES(4), .FIXED_PRIORITY(0)) u_rr (
        .clk(clk), .reset_n(reset_n), .m0(a_m0), .m1(a_m1), .s(a_s),
        .grant(a_grant), .timeout_err(a_terr));
    mem_arbiter #(.TIMEOUT_CYCLES(1), .FIXED_PRIORITY(1)) u_fx (
        .clk(clk), .reset_n(reset_n), .m0(b_m0), .m1(b_m1), .s(b_s),
        .grant(b_grant), .timeout_err(b_terr));

    // Master index k = dut*2 + master
    logic        mv[4], mi[4];
    logic [31:0] ma[4], mw[4];
    logic [3:0]  ms[4];
    logic        sr[2];
    logic [31:0] srd[2];
    logic        o_mr[4];
    logic [31:0] o_mrd[4];
    logic        o_sv[2], o_si[2], o_te[2];
    logic [31:0] o_sa[2], o_sw[2];
    logic [3:0]  o_ss[2];
    logic [1:0]  o_gr[2];

    assign a_m0.valid = mv[0]; assign a_m0.instr = mi[0]; assign a_m0.addr = ma[0];
    assign a_m0.wdata = mw[0]; assign a_m0.wstrb = ms[0];
    assign a_m1.valid = mv[1]; assign a_m1.instr = mi[1]; assign a_m1.addr = ma[1];
    assign a_m1.wdata = mw[1]; assign a_m1.wstrb = ms[1];
    assign b_m0.valid = mv[2]; assign b_m0.instr = mi[2]; assign b_m0.addr = ma[2];
    assign b_m0.wdata = mw[2]; assign b_m0.wstrb = ms[2];
    assign b_m1.valid = mv[3]; assign b_m1.instr = mi[3]; assign b_m1.addr = ma[3];
    assign b_m1.wdata = mw[3]; assign b_m1.wstrb = ms[3];
    assign a_s.ready  = sr[0]; assign a_s.rdata = srd[0];
    assign b_s.ready  = sr[1]; assign b_s.rdata = srd[1];

    assign o_mr[0] = a_m0.ready; assign o_mrd[0] = a_m0.rdata;
    assign o_mr[1] = a_m1.ready; assign o_mrd[1] = a_m1.rdata;
    assign o_mr[2] = b_m0.ready; assign o_mrd[2] = b_m0.rdata;
    assign o_mr[3] = b_m1.ready; assign o_mrd[3] = b_m1.rdata;
    assign o_sv[0] = a_s.valid;  assign o_si[0] = a_s.instr; assign o_sa[0] = a_s.addr;
    assign o_sw[0] = a_s.wdata;  assign o_ss[0] = a_s.wstrb;
    assign o_sv[1] = b_s.valid;  assign o_si[1] = b_s.instr; assign o_sa[1] = b_s.addr;
    assign o_sw[1] = b_s.wdata;  assign o_ss[1] = b_s.wstrb;
    assign o_gr[0] = a_grant;    assign o_te[0] = a_terr;
    assign o_gr[1] = b_grant;    assign o_te[1] = b_terr;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owner -1 = bus free; fav = master that wins the next tie
    int          tcy[2], fp[2];
    int          owner[2], age[2], fav[2];
    bit          terr[2], prev_done[2], p_to[2], p_done[2];
    bit          pend[4], cool[4];
    int          rand_en[2], smode[2];
    logic [31:0] mem[2][256];
    logic [31:0] lastrd[4];
    int          served_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_chk++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", tag, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1; age[d] = 0; fav[d] = 0; terr[d] = 0; prev_done[d] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            pend[k] = 0; cool[k] = 0; mv[k] = 1'b0;
        end
    endtask

    task automatic new_req(input int k);
        ma[k]   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        mw[k]   = $urandom;
        ms[k]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        mi[k]   = 1'($urandom_range(0, 1));
        pend[k] = 1;
    endtask

    task automatic drive();
        int k;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                k = d * 2 + m;
                if (!pend[k]) begin
                    if (cool[k]) cool[k] = 0;
                    else if (rand_en[d] != 0 && $urandom_range(0, (d == 1) ? 1 : 3) == 0) new_req(k);
                end
                mv[k] = pend[k];
            end
            if (owner[d] >= 0) begin
                k = d * 2 + owner[d];
                case (smode[d])
                    1:       sr[d] = 1'b0;
                    2:       sr[d] = 1'b1;
                    default: sr[d] = ($urandom_range(0, 2) == 0);
                endcase
                srd[d] = (ms[k] == 4'h0) ? mem[d][ma[k][9:2]] : $urandom;
            end else begin
                sr[d]  = (smode[d] != 1) && ($urandom_range(0, 3) == 0);
                srd[d] = $urandom;
            end
        end
    endtask

    task automatic check();
        int k, kk;
        bit to_now, dn, rdy;
        logic [1:0] exp_gr;
        for (int d = 0; d < 2; d++) begin
            k      = (owner[d] >= 0) ? d * 2 + owner[d] : 0;
            to_now = (tcy[d] != 0) && (owner[d] >= 0) && !sr[d] && (age[d] == tcy[d] - 1);
            dn     = (owner[d] >= 0) && (sr[d] || to_now);
            exp_gr = (owner[d] == 0) ? 2'b01 : (owner[d] == 1) ? 2'b10 : 2'b00;
            chk($sformatf("d%0d.grant", d), o_gr[d], exp_gr);
            chk($sformatf("d%0d.s_valid", d), o_sv[d], owner[d] >= 0);
            chk($sformatf("d%0d.s_addr", d), o_sa[d], (owner[d] >= 0) ? ma[k] : 32'h0);
            chk($sformatf("d%0d.s_wdata", d), o_sw[d], (owner[d] >= 0) ? mw[k] : 32'h0);
            chk($sformatf("d%0d.s_wstrb", d), o_ss[d], (owner[d] >= 0) ? ms[k] : 4'h0);
            chk($sformatf("d%0d.s_instr", d), o_si[d], (owner[d] >= 0) ? mi[k] : 1'b0);
            chk($sformatf("d%0d.timeout_err", d), o_te[d], terr[d]);
            if (prev_done[d]) chk($sformatf("d%0d.turnaround", d), o_sv[d], 1'b0);
            for (int m = 0; m < 2; m++) begin
                kk  = d * 2 + m;
                rdy = (owner[d] == m) && dn;
                chk($sformatf("d%0d.m%0d_ready", d, m), o_mr[kk], rdy);
                if (rdy) begin
                    chk($sformatf("d%0d.m%0d_rdata", d, m), o_mrd[kk], to_now ? 32'h0 : srd[d]);
                    lastrd[kk] = o_mrd[kk];
                end
            end
            p_to[d]   = to_now;
            p_done[d] = dn;
        end
    endtask

    task automatic advance();
        int k;
        for (int d = 0; d < 2; d++) begin
            if (owner[d] < 0) begin
                if (pend[d * 2] && pend[d * 2 + 1]) owner[d] = (fp[d] != 0) ? 0 : fav[d];
                else if (pend[d * 2])               owner[d] = 0;
                else if (pend[d * 2 + 1])           owner[d] = 1;
                age[d]       = 0;
                prev_done[d] = 0;
            end else if (p_done[d]) begin
                k = d * 2 + owner[d];
                if (!p_to[d]) begin
                    for (int b = 0; b < 4; b++)
                        if (ms[k][b]) mem[d][ma[k][9:2]][b * 8 +: 8] = mw[k][b * 8 +: 8];
                end else begin
                    terr[d] = 1;
                end
                fav[d]  = 1 - owner[d];
                pend[k] = 0;
                cool[k] = 1;
                if (d == 0) served_q.push_back(owner[d]);
                owner[d]     = -1;
                prev_done[d] = 1;
            end else begin
                age[d]++;
                prev_done[d] = 0;
            end
        end
    endtask

    task automatic step();
        drive();
        #2;
        check();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input int m, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input logic instr);
        int k, n;
        k = d * 2 + m;
        n = 0;
        while ((pend[k] || cool[k]) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) bound_fail("issue_wait");
        ma[k] = addr; mw[k] = wdata; ms[k] = wstrb; mi[k] = instr;
        pend[k] = 1;
    endtask

    task automatic wait_done(input int d, input int m);
        int k, n;
        k = d * 2 + m;
        n = 0;
        while (pend[k] && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) bound_fail($sformatf("d%0d.m%0d_done", d, m));
    endtask

    function automatic logic [31:0] prog_word(input int i);
        if (i < 3)  return 32'h0000_0013;
        if (i == 3) return 32'h0000_006F;
        return 32'hA500_0000 | 32'(i);
    endfunction

    initial begin
        int n;
        tcy = '{4, 1};
        fp  = '{0, 1};
        rand_en = '{0, 0};
        smode   = '{0, 0};
        for (int k = 0; k < 4; k++) begin
            ma[k] = '0; mw[k] = '0; ms[k] = '0; mi[k] = 1'b0; lastrd[k] = '0;
        end
        for (int d = 0; d < 2; d++) begin
            sr[d] = 1'b0; srd[d] = '0;
            for (int i = 0; i < 256; i++) mem[d][i] = '0;
        end
        model_reset();
        reset_n = 1'b0;

        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst.d%0d.grant", d), o_gr[d], 2'b00);
            chk($sformatf("rst.d%0d.s_valid", d), o_sv[d], 1'b0);
            chk($sformatf("rst.d%0d.s_addr", d), o_sa[d], 32'h0);
            chk($sformatf("rst.d%0d.m0_ready", d), o_mr[d * 2], 1'b0);
            chk($sformatf("rst.d%0d.m1_ready", d), o_mr[d * 2 + 1], 1'b0);
            chk($sformatf("rst.d%0d.timeout_err", d), o_te[d], 1'b0);
        end
        @(posedge clk); @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        rand_en[1] = 1;

        // Tie straight out of reset: master 0 first, then master 1
        smode[0] = 2;
        served_q.delete();
        issue(0, 0, 32'h40, 32'h1111_2222, 4'hF, 1'b0);
        issue(0, 1, 32'h44, 32'h3333_4444, 4'hF, 1'b0);
        wait_done(0, 0);
        wait_done(0, 1);
        chk("rr1.count", served_q.size(), 2);
        if (served_q.size() == 2) begin
            chk("rr1.first", served_q[0], 0);
            chk("rr1.second", served_q[1], 1);
        end

        // Single write then read-back through master 0
        issue(0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        wait_done(0, 0);
        issue(0, 0, 32'h0000_0010, 32'h0, 4'b0000, 1'b0);
        wait_done(0, 0);
        chk("readback", lastrd[0], 32'hDEAD_BEEF);

        // Master 0 completed last, so master 1 now wins the tie
        served_q.delete();
        issue(0, 0, 32'h48, 32'h5555_6666, 4'hF, 1'b0);
        issue(0, 1, 32'h4C, 32'h7777_8888, 4'hF, 1'b0);
        wait_done(0, 0);
        wait_done(0, 1);
        chk("rr2.count", served_q.size(), 2);
        if (served_q.size() == 2) begin
            chk("rr2.first", served_q[0], 1);
            chk("rr2.second", served_q[1], 0);
        end

        // Hung slave: master 0 gets a zero-data completion, error stays sticky
        smode[0] = 1;
        lastrd[0] = 32'hFFFF_FFFF;
        issue(0, 0, 32'h10, 32'h0, 4'h0, 1'b0);
        wait_done(0, 0);
        chk("timeout.rdata", lastrd[0], 32'h0);
        chk("timeout.err", o_te[0], 1'b1);
        smode[0] = 2;
        issue(0, 1, 32'h24, 32'h1234_5678, 4'hF, 1'b0);
        wait_done(0, 1);
        issue(0, 1, 32'h24, 32'h0, 4'h0, 1'b0);
        wait_done(0, 1);
        chk("after_timeout.rdata", lastrd[1], 32'h1234_5678);
        chk("after_timeout.err", o_te[0], 1'b1);

        // Asynchronous reset while master 1 holds the bus
        smode[0] = 1;
        issue(0, 1, 32'h30, 32'h0, 4'h0, 1'b0);
        step();
        step();
        sr[0] = 1'b1;
        #1;
        chk("pre_rst.m1_ready", o_mr[1], 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_rst.s_valid", o_sv[0], 1'b0);
        chk("async_rst.m1_ready", o_mr[1], 1'b0);
        chk("async_rst.grant", o_gr[0], 2'b00);
        chk("async_rst.timeout_err", o_te[0], 1'b0);
        model_reset();
        sr[0] = 1'b0;
        sr[1] = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        smode[0] = 2;
        served_q.delete();
        issue(0, 0, 32'h50, 32'h0, 4'h0, 1'b0);
        issue(0, 1, 32'h54, 32'h0, 4'h0, 1'b0);
        wait_done(0, 0);
        wait_done(0, 1);
        chk("post_rst.count", served_q.size(), 2);
        if (served_q.size() == 2) chk("post_rst.first", served_q[0], 0);

        // Program load through master 1, then instruction fetches through master 0
        for (int i = 0; i < 255; i++) begin
            issue(0, 1, 32'(i * 4), prog_word(i), 4'hF, 1'b0);
            wait_done(0, 1);
        end
        for (int i = 0; i < 4; i++) begin
            issue(0, 0, 32'(i * 4), 32'h0, 4'h0, 1'b1);
            wait_done(0, 0);
            chk($sformatf("fetch%0d", i), lastrd[0], prog_word(i));
        end

        // Free-running random traffic on both instances
        rand_en  = '{1, 1};
        smode    = '{0, 0};
        repeat (3000) step();
        rand_en = '{0, 0};
        n = 0;
        while ((pend[0] || pend[1] || pend[2] || pend[3]) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) bound_fail("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
